// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu
// Description : Handshaked 32-bit ALU. AND/OR/XOR/ADD/SUB complete in one
//               cycle; SLL/SRL/SRA shift a working register one bit per cycle
//               for shamt cycles. Unsupported op codes give result 0 with
//               the illegal flag set.
// Ports       : clk_i            - clock, rising edge
//               rst_i            - synchronous active-high reset
//               in_valid_i       - request valid
//               in_ready_o       - request can be accepted (IDLE only)
//               alu_control_op_i - operation code
//               a_i, b_i         - operands (b_i[4:0] = shift amount)
//               out_valid_o      - result valid (DONE)
//               out_ready_i      - consumer takes the result
//               result_o         - registered result
//               zero_o           - result_o == 0
//               illegal_o        - captured op code was unsupported
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      alu_control_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRL = 4'b0101;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SRA = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_work;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    logic            w_accept;
    logic            w_is_shift;
    logic            w_go_shift;
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_ill;
    logic [XLEN-1:0] w_shift_step;

    assign w_is_shift = (alu_control_op_i == c_OP_SLL) ||
                        (alu_control_op_i == c_OP_SRL) ||
                        (alu_control_op_i == c_OP_SRA);
    assign w_accept   = in_valid_i && (r_state == S_IDLE);
    // A zero shift amount takes the single-cycle path with result = a.
    assign w_go_shift = w_is_shift && (b_i[4:0] != 5'd0);

    // Single-cycle result, evaluated from the live inputs on the accept edge.
    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (alu_control_op_i)
            c_OP_AND: w_alu_res = a_i & b_i;
            c_OP_OR:  w_alu_res = a_i | b_i;
            c_OP_XOR: w_alu_res = a_i ^ b_i;
            c_OP_ADD: w_alu_res = a_i + b_i;
            c_OP_SUB: w_alu_res = a_i - b_i;
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRA: w_alu_res = a_i;
            default:  w_alu_ill = 1'b1;
        endcase
    end

    // One-bit step of the captured shift op. SRA keeps replicating the MSB,
    // which still holds the sign bit of the captured operand.
    always_comb begin
        w_shift_step = r_work;
        case (r_op)
            c_OP_SLL: w_shift_step = {r_work[XLEN-2:0], 1'b0};
            c_OP_SRL: w_shift_step = {1'b0, r_work[XLEN-1:1]};
            default:  w_shift_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_go_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 5'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= alu_control_op_i;
                        r_work <= a_i;
                        r_cnt  <= w_is_shift ? b_i[4:0] : 5'd0;
                        if (!w_go_shift) begin
                            r_result  <= w_alu_res;
                            r_illegal <= w_alu_ill;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shift_step;
                    r_cnt  <= r_cnt - 5'd1;
                    // Result is published only with the last shift step.
                    if (r_cnt == 5'd1) begin
                        r_result  <= w_shift_step;
                        r_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o  = r_result;
    assign zero_o    = (r_result == '0);
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu
// Description : Directed self-checking bench for serial_alu with
//               hand-computed expected results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_control_op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    int n_chk  = 0;
    int n_pass = 0;

    serial_alu #(.XLEN(32)) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .alu_control_op_i (alu_control_op_i),
        .a_i              (a_i),
        .b_i              (b_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .result_o         (result_o),
        .zero_o           (zero_o),
        .illegal_o        (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one request from a negedge, measure latency, check, then handshake.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill,
                          input int exp_lat);
        int   lat;
        logic rdy_bad;
        check({tag, ":in_ready"}, {31'd0, in_ready_o}, 32'd1);
        in_valid_i       = 1'b1;
        alu_control_op_i = op;
        a_i              = a;
        b_i              = b;
        @(posedge clk_i);
        @(negedge clk_i);
        // Scramble inputs to confirm only the captured values matter.
        in_valid_i       = 1'b0;
        alu_control_op_i = ~op;
        a_i              = ~a;
        b_i              = ~b;
        lat     = 1;
        rdy_bad = 1'b0;
        while (!out_valid_o && lat < 64) begin
            if (in_ready_o) rdy_bad = 1'b1;
            @(negedge clk_i);
            lat++;
        end
        check({tag, ":latency"},  lat, exp_lat);
        check({tag, ":busy_rdy"}, {31'd0, rdy_bad}, 32'd0);
        check({tag, ":result"},   result_o, exp_res);
        check({tag, ":zero"},     {31'd0, zero_o}, {31'd0, (exp_res == 32'd0)});
        check({tag, ":illegal"},  {31'd0, illegal_o}, {31'd0, exp_ill});
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check({tag, ":post_valid"},  {31'd0, out_valid_o}, 32'd0);
        check({tag, ":post_ready"},  {31'd0, in_ready_o}, 32'd1);
        check({tag, ":post_hold"},   result_o, exp_res);
        check({tag, ":post_ill"},    {31'd0, illegal_o}, {31'd0, exp_ill});
    endtask

    initial begin
        int seen;
        rst_i            = 1'b1;
        in_valid_i       = 1'b0;
        out_ready_i      = 1'b0;
        alu_control_op_i = 4'd0;
        a_i              = 32'd0;
        b_i              = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        check("rst:out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst:in_ready",  {31'd0, in_ready_o}, 32'd1);
        check("rst:result",    result_o, 32'd0);
        check("rst:zero",      {31'd0, zero_o}, 32'd1);
        check("rst:illegal",   {31'd0, illegal_o}, 32'd0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
        run_op("sub_zero", 4'b0110, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 1);
        run_op("and",     4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        run_op("or",      4'b0001, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0, 1);
        run_op("xor",     4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
        run_op("sub_wrap", 4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("illegal", 4'b1000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1);
        run_op("sra_neg", 4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5);
        run_op("sll_25",  4'b0100, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1'b0, 6);
        run_op("srl_0",   4'b0101, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1);
        run_op("srl_31",  4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32);
        run_op("sra_pos", 4'b0111, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 2);
        run_op("ill_1111", 4'b1111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);

        // Back-pressure: result held while new requests are presented.
        in_valid_i       = 1'b1;
        alu_control_op_i = 4'b0010;
        a_i              = 32'd5;
        b_i              = 32'd6;
        @(posedge clk_i);
        @(negedge clk_i);
        check("stall:valid", {31'd0, out_valid_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            a_i        = 32'h1000 + i;
            b_i        = 32'h2000 + i;
            @(negedge clk_i);
            check("stall:result", result_o, 32'd11);
            check("stall:valid_hold", {31'd0, out_valid_o}, 32'd1);
            check("stall:not_ready", {31'd0, in_ready_o}, 32'd0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("stall:idle_ready", {31'd0, in_ready_o}, 32'd1);
        check("stall:idle_valid", {31'd0, out_valid_o}, 32'd0);
        check("stall:idle_result", result_o, 32'd11);

        // Reset two cycles into a 31-bit SLL discards the operation.
        in_valid_i       = 1'b1;
        alu_control_op_i = 4'b0100;
        a_i              = 32'h0000_0001;
        b_i              = 32'h0000_001F;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_shift:valid",  {31'd0, out_valid_o}, 32'd0);
        check("rst_shift:ready",  {31'd0, in_ready_o}, 32'd1);
        check("rst_shift:result", result_o, 32'd0);
        check("rst_shift:zero",   {31'd0, zero_o}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1;
        end
        check("rst_shift:no_pulse", seen, 0);

        // Reset in DONE wins over a simultaneous output handshake.
        in_valid_i       = 1'b1;
        alu_control_op_i = 4'b0010;
        a_i              = 32'd2;
        b_i              = 32'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("rst_done:pre_result", result_o, 32'd5);
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        rst_i       = 1'b0;
        out_ready_i = 1'b0;
        check("rst_done:valid",  {31'd0, out_valid_o}, 32'd0);
        check("rst_done:result", result_o, 32'd0);
        check("rst_done:ready",  {31'd0, in_ready_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 needs to be supported.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid_i  input  1  request valid.
REQ-005 SHALL have port in_ready_o  output  1  block can accept a request.
REQ-006 SHALL have port alu_control_op_i  input  4  operation code.
REQ-007 SHALL have port a_i  input  XLEN  operand A.
REQ-008 SHALL have port b_i  input  XLEN  operand B; low 5 bits are the shift amount for shift ops.
REQ-009 SHALL have port out_valid_o  output  1  result valid.
REQ-010 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port result_o  output  XLEN  registered result.
REQ-012 SHALL have port zero_o  output  1  result_o == 0.
REQ-013 SHALL have port illegal_o  output  1  captured op code was unsupported.

Function
REQ-014 SHALL decode ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA; all others are illegal.
REQ-015 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL drive in_ready_o = 1 only in IDLE; accept means in_valid_i & in_ready_o on a clock edge.
REQ-017 SHALL capture op, a_i and b_i[4:0] on accept, and SHALL ignore later input changes until the next accept.
REQ-018 SHALL, for non-shift ops (legal or illegal), compute the result on accept and go IDLE -> DONE; out_valid_o rises on the next cycle (latency 1).
REQ-019 SHALL, for a shift op with shamt = 0, go IDLE -> DONE with result = a (latency 1).
REQ-020 SHALL, for a shift op with shamt > 0, go IDLE -> SHIFT and shift the working register by one bit per cycle for shamt cycles, then go to DONE; out_valid_o rises exactly 1 + shamt cycles after accept.
REQ-021 SHALL fill SLL from the LSB side and SRL from the MSB side with 0, and SHALL fill SRA from the MSB side with the captured sign bit a[31].
REQ-022 SHALL perform ADD/SUB modulo 2^XLEN, with no carry or overflow output.
REQ-023 SHALL produce result 0 and illegal_o = 1 for illegal ops; illegal_o = 0 for all legal ops.
REQ-024 SHALL hold out_valid_o = 1 in DONE, with result_o, zero_o and illegal_o stable, until out_valid_o & out_ready_i, then go to IDLE.
REQ-025 SHALL keep result_o, zero_o and illegal_o at their last values after the handshake, until the next result is produced.
REQ-026 SHALL keep in_ready_o = 0 in SHIFT and DONE, and SHALL ignore in_valid_i in those states.
REQ-027 SHALL make the minimum request-to-request spacing 2 cycles: accept, DONE+handshake, then IDLE.
REQ-028 SHALL compute zero_o from the registered result, not from the inputs.

Reset
REQ-029 SHALL, when rst_i = 1 at a clock edge, go to IDLE regardless of state, including mid-SHIFT and in DONE before the handshake.
REQ-030 SHALL, after reset, drive out_valid_o = 0, in_ready_o = 1, result_o = 0, zero_o = 1, illegal_o = 0, and shift counter = 0.
REQ-031 SHALL discard any in-flight operation on reset; no result is produced for it.
REQ-032 SHALL let reset take priority over a simultaneous accept or output handshake.

Verification
REQ-033 SHALL cover: ADD a=0x7FFFFFFF, b=1, out_ready_i=1 -> result_o=0x80000000, zero_o=0, out_valid_o 1 cycle after accept.
REQ-034 SHALL cover: SUB a=b=0x00001234 -> result_o=0, zero_o=1, illegal_o=0.
REQ-035 SHALL cover: SRA a=0x80000000, b=4 -> result_o=0xF8000000, out_valid_o 5 cycles after accept, in_ready_o=0 throughout; SLL a=1, b=0x25 -> 0x00000020 after 6 cycles; SRL b=0 -> result=a after 1 cycle.
REQ-036 SHALL cover: out_ready_i low for 3 cycles in DONE while in_valid_i pulses with new operands -> result_o held stable, request not accepted, IDLE the cycle after out_ready_i=1.
REQ-037 SHALL cover: op 1000 with a=0xFFFFFFFF -> result_o=0, zero_o=1, illegal_o=1, latency 1.
REQ-038 SHALL cover: rst_i asserted 2 cycles into SLL shamt=31 -> next cycle out_valid_o=0, in_ready_o=1, result_o=0; no out_valid_o pulse for that shift afterward.
